audio_clock_gen: RTL

Generates the codec clocks (mclk, bclk, lrclk) from `sys_clk` and sequences the codec power-up and datapath reset against PLL lock. It sits directly upstream of the I2S transceiver, which samples `bclk`/`lrclk`, and replaces the ad-hoc divider logic in the top level. It provides one-cycle strobes aligned to bclk and frame edges so downstream logic stays synchronous to `sys_clk`.

---
 rtl/audio_clock_gen.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/audio_clock_gen.sv
// Codec clock generator: mclk/bclk/lrclk divider chain with
// PLL-lock power sequencing and sys_clk-aligned strobes.
module audio_clock_gen #(
  parameter int MCLK_HALF     = 5,
  parameter int BCLK_TICKS    = 2,
  parameter int SLOT_BITS     = 32,
  parameter int SETTLE_CYCLES = 1024
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic pll_lock,
  input  logic enable,
  output logic mclk,
  output logic bclk,
  output logic lrclk,
  output logic codec_en,
  output logic run_reset,
  output logic bclk_fall,
  output logic frame_start,
  output logic lock_lost
);

  localparam int TW = $clog2(MCLK_HALF);
  localparam int BW = $clog2(BCLK_TICKS) + 1;
  localparam int SW = $clog2(SLOT_BITS);
  localparam int CW = $clog2(SETTLE_CYCLES) + 1;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    SETTLE,
    RUN
  } state_t;

  state_t        state;
  logic          lock_m;
  logic          lock_s;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bclk_cnt;
  logic [SW-1:0] slot_cnt;
  logic [CW-1:0] settle_cnt;

  logic tick;
  logic bwrap;
  logic swrap;
  logic settle_done;
  logic go_idle;

  assign tick        = (tick_cnt == TW'(MCLK_HALF - 1));
  assign bwrap       = (bclk_cnt == BW'(BCLK_TICKS - 1));
  assign swrap       = (slot_cnt == SW'(SLOT_BITS - 1));
  assign settle_done = (settle_cnt == CW'(SETTLE_CYCLES - 1));
  assign go_idle     = !lock_s || !enable;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state       <= WAIT_LOCK;
      tick_cnt    <= '0;
      bclk_cnt    <= '0;
      slot_cnt    <= '0;
      settle_cnt  <= '0;
      mclk        <= 1'b0;
      bclk        <= 1'b0;
      lrclk       <= 1'b0;
      codec_en    <= 1'b0;
      run_reset   <= 1'b1;
      bclk_fall   <= 1'b0;
      frame_start <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      codec_en    <= lock_s & enable;
      bclk_fall   <= 1'b0;
      frame_start <= 1'b0;
      // Losing lock/enable beats any pending tick toggle.
      if (go_idle) begin
        if (state == RUN && !lock_s)
          lock_lost <= 1'b1;
        state      <= WAIT_LOCK;
        tick_cnt   <= '0;
        bclk_cnt   <= '0;
        slot_cnt   <= '0;
        settle_cnt <= '0;
        mclk       <= 1'b0;
        bclk       <= 1'b0;
        lrclk      <= 1'b0;
        run_reset  <= 1'b1;
      end else begin
        unique case (state)
          WAIT_LOCK: begin
            state <= SETTLE;
          end
          SETTLE: begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (!settle_done)
              settle_cnt <= settle_cnt + CW'(1);
            if (tick) begin
              mclk <= ~mclk;
              if (settle_done) begin
                state     <= RUN;
                run_reset <= 1'b0;
              end
            end
          end
          RUN: begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            if (tick) begin
              mclk <= ~mclk;
              if (bwrap) begin
                bclk_cnt <= '0;
                bclk     <= ~bclk;
                // lrclk only moves while bclk goes low.
                if (bclk) begin
                  bclk_fall <= 1'b1;
                  slot_cnt  <= slot_cnt + SW'(1);
                  if (swrap) begin
                    lrclk       <= ~lrclk;
                    frame_start <= lrclk;
                  end
                end
              end else begin
                bclk_cnt <= bclk_cnt + BW'(1);
              end
            end
          end
          default: state <= WAIT_LOCK;
        endcase
      end
    end
  end

endmodule
